// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer driving a 4-bit carry-lookahead ALU slice, LSB nibble first.
// Optional ALU_NIBBLE_SEQ_ZERO_FLAG_EN adds a registered all-zero result flag.
module alu_nibble_seq #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic             m,
  input  logic             cin_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_n,
  output logic             eq,
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic [3:0]       slice_sel,
  output logic             slice_m,
  output logic             slice_cin,
  input  logic [3:0]       slice_f,
  input  logic             slice_cn4,
  input  logic             slice_eq
);

  localparam int unsigned     IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             eqacc_q, eqacc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       sel_q, sel_d;
  logic             m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_n_q, cout_n_d;
  logic             eq_q, eq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  // Slice is fed straight from latched operands; carry stays active-low throughout.
  assign slice_a   = a_q[{idx_q, 2'b00} +: 4];
  assign slice_b   = b_q[{idx_q, 2'b00} +: 4];
  assign slice_sel = sel_q;
  assign slice_m   = m_q;
  assign slice_cin = carry_q;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout_n = cout_n_q;
  assign eq     = eq_q;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  assign zero   = zero_q;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    eqacc_d  = eqacc_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    m_d      = m_q;
    result_d = result_q;
    cout_n_d = cout_n_q;
    eq_d     = eq_q;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          sel_d    = sel;
          m_d      = m;
          carry_d  = cin_n;
          idx_d    = '0;
          eqacc_d  = 1'b1;
          result_d = '0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
          zero_d   = 1'b0;
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = slice_f;
        carry_d = slice_cn4;
        eqacc_d = eqacc_q & slice_eq;
        if (idx_q == LAST_IDX) begin
          // Flags are registered on the way into DONE so they are valid with done.
          cout_n_d = m_q | slice_cn4;
          eq_d     = eqacc_q & slice_eq;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
          zero_d   = (result_d == '0);
`endif
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      eqacc_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      m_q      <= 1'b0;
      result_q <= '0;
      cout_n_q <= 1'b1;
      eq_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      eqacc_q  <= eqacc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      m_q      <= m_d;
      result_q <= result_d;
      cout_n_q <= cout_n_d;
      eq_q     <= eq_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: behavioural ALU slice plus a word-level reference model.
module tb_alu_nibble_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst, start, m, cin_n;
  logic [3:0]   sel;
  logic [W-1:0] a, b;
  logic         busy, done, cout_n, eq;
  logic [W-1:0] result;
  logic [3:0]   slice_a, slice_b, slice_sel, slice_f;
  logic         slice_m, slice_cin, slice_cn4, slice_eq;
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .m(m), .cin_n(cin_n),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .cout_n(cout_n), .eq(eq),
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    .zero(zero),
`endif
    .slice_a(slice_a), .slice_b(slice_b), .slice_sel(slice_sel),
    .slice_m(slice_m), .slice_cin(slice_cin), .slice_f(slice_f),
    .slice_cn4(slice_cn4), .slice_eq(slice_eq)
  );

  // Behavioural slice: add (1001) / subtract (0110) in arithmetic mode; xor/and/or/xnor in logic mode.
  logic [4:0] slice_t;
  always_comb begin
    if (!slice_m && slice_sel == 4'b0110)
      slice_t = {1'b0, slice_a} + {1'b0, ~slice_b} + 5'(!slice_cin);
    else
      slice_t = {1'b0, slice_a} + {1'b0, slice_b} + 5'(!slice_cin);
    if (!slice_m) slice_f = slice_t[3:0];
    else begin
      case (slice_sel)
        4'b0110: slice_f = slice_a ^ slice_b;
        4'b1011: slice_f = slice_a & slice_b;
        4'b1110: slice_f = slice_a | slice_b;
        default: slice_f = ~(slice_a ^ slice_b);
      endcase
    end
    slice_cn4 = ~slice_t[4];
    slice_eq  = (slice_a == slice_b);
  end

  // Whole-word reference computed with plain arithmetic.
  task automatic ref_op(input logic [3:0] s, input logic mm, input logic cn,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output logic [W-1:0] r, output logic co_n, output logic e);
    logic [W:0] t;
    e = (aa == bb);
    if (!mm) begin
      if (s == 4'b0110) t = {1'b0, aa} + {1'b0, ~bb} + (W+1)'(!cn);
      else              t = {1'b0, aa} + {1'b0, bb} + (W+1)'(!cn);
      r    = t[W-1:0];
      co_n = ~t[W];
    end else begin
      case (s)
        4'b0110: r = aa ^ bb;
        4'b1011: r = aa & bb;
        4'b1110: r = aa | bb;
        default: r = ~(aa ^ bb);
      endcase
      co_n = 1'b1;
    end
  endtask

  // Run one operation from IDLE and check latency, flags and per-nibble carry-in.
  task automatic do_op(input string nm, input logic [3:0] s, input logic mm, input logic cn,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] er, input logic eco, input logic ee);
    int     cyc;
    bit     got;
    logic   cins[$];
    logic [31:0] mask, lo, bx;
    logic   exp_cin;
    sel = s; m = mm; cin_n = cn; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    cyc = 1; got = 0;
    while (cyc <= 20) begin
      if (done) begin got = 1; break; end
      if (busy) cins.push_back(slice_cin);
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (!got || cyc != NIBBLES + 1) begin
      n_fail++; $display("FAIL %s latency: got=%0d cycle=%0d required cycle %0d", nm, got, cyc, NIBBLES + 1);
    end
    n_tests++;
    if (result !== er) begin n_fail++; $display("FAIL %s result: got %h required %h", nm, result, er); end
    n_tests++;
    if (cout_n !== eco) begin n_fail++; $display("FAIL %s cout_n: got %b required %b", nm, cout_n, eco); end
    n_tests++;
    if (eq !== ee) begin n_fail++; $display("FAIL %s eq: got %b required %b", nm, eq, ee); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_in_done: got %b required 0", nm, busy); end
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    n_tests++;
    if (zero !== (er == '0)) begin n_fail++; $display("FAIL %s zero: got %b required %b", nm, zero, (er == '0)); end
`endif
    n_tests++;
    if (cins.size() != NIBBLES) begin
      n_fail++; $display("FAIL %s run_cycles: got %0d required %0d", nm, cins.size(), NIBBLES);
    end else if (!mm) begin
      bx = (s == 4'b0110) ? 32'(~bb) : 32'(bb);
      for (int i = 0; i < NIBBLES; i++) begin
        mask = (32'd1 << (4 * i)) - 32'd1;
        lo   = (32'(aa) & mask) + (bx & mask) + 32'(!cn);
        exp_cin = ~lo[4 * i];
        n_tests++;
        if (cins[i] !== exp_cin) begin
          n_fail++; $display("FAIL %s slice_cin[%0d]: got %b required %b", nm, i, cins[i], exp_cin);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse_width: got %b required 0", nm, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 4'hF; m = 1'b1; cin_n = 1'b0; a = '1; b = '1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, result, cout_n, eq} !== {1'b0, 1'b0, W'(0), 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout_n=%b eq=%b required 0 0 0000 1 0",
                         busy, done, result, cout_n, eq);
    end
    n_tests++;
    if ({slice_a, slice_b, slice_sel, slice_m, slice_cin} !== {4'h0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_slice: got a=%h b=%h sel=%h m=%b cin=%b required 0 0 0 0 1",
                         slice_a, slice_b, slice_sel, slice_m, slice_cin);
    end
`ifdef ALU_NIBBLE_SEQ_ZERO_FLAG_EN
    n_tests++;
    if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b required 0", zero); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op("add_nocarry", 4'b1001, 1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5555, 1'b1, 1'b0);
    do_op("add_ripple",  4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    do_op("sub_noborrow",4'b0110, 1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    do_op("sub_borrow",  4'b0110, 1'b0, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
    do_op("xor_logic",   4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b1, 1'b0);
    do_op("eq_equal",    4'b1001, 1'b1, 1'b1, 16'hABCD, 16'hABCD, 16'hFFFF, 1'b1, 1'b1);
    do_op("eq_differ",   4'b1001, 1'b1, 1'b1, 16'hABCD, 16'hABCC, 16'hFFFE, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0]   s;
    logic         mm, cn, eco, ee;
    logic [W-1:0] aa, bb, er;
    logic [3:0]   lsel [4] = '{4'b1001, 4'b0110, 4'b1011, 4'b1110};
    for (int k = 0; k < 40; k++) begin
      mm = 1'($urandom);
      s  = mm ? lsel[$urandom_range(3, 0)] : lsel[$urandom_range(1, 0)];
      cn = 1'($urandom);
      aa = W'($urandom);
      bb = ($urandom_range(3, 0) == 0) ? aa : W'($urandom);
      ref_op(s, mm, cn, aa, bb, er, eco, ee);
      do_op("random", s, mm, cn, aa, bb, er, eco, ee);
    end
  endtask

  // start held for 10 cycles: two operations, done in cycles 5 and 11; a changed mid-RUN.
  task automatic test_back_to_back();
    int        dcyc[$];
    logic [W-1:0] res[$];
    sel = 4'b1001; m = 1'b0; cin_n = 1'b1; a = 16'h1111; b = 16'h2222; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 2) a = 16'h3030;
      if (c == 10) start = 1'b0;
      if (done) begin dcyc.push_back(c); res.push_back(result); end
    end
    n_tests++;
    if (dcyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d required 2", dcyc.size());
    end else begin
      n_tests++;
      if (dcyc[0] != 5 || dcyc[1] != 11) begin
        n_fail++; $display("FAIL b2b_done_cycles: got %0d,%0d required 5,11", dcyc[0], dcyc[1]);
      end
      n_tests++;
      if (res[0] !== 16'h3333 || res[1] !== 16'h5252) begin
        n_fail++; $display("FAIL b2b_results: got %h,%h required 3333,5252", res[0], res[1]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    sel = 4'b1001; m = 1'b0; cin_n = 1'b0; a = 16'h7777; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({busy, done, result, cout_n, slice_cin} !== {1'b0, 1'b0, W'(0), 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL midreset_state: got busy=%b done=%b result=%h cout_n=%b slice_cin=%b required 0 0 0000 1 1",
                         busy, done, result, cout_n, slice_cin);
    end
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    n_tests++;
    if (ndone != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d active cycles required 0", ndone); end
    do_op("after_reset", 4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0F01, 16'h1000, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = '0; m = 1'b0; cin_n = 1'b1; a = '0; b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    @(posedge clk); #1;
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
